// File: rtl/breakout_pkg.sv
// rtl/breakout_pkg.sv - shared state encoding and default constants for the game sequencer
package breakout_pkg;

    typedef enum logic [2:0] {
        ST_ATTRACT    = 3'd0,
        ST_SERVE_WAIT = 3'd1,
        ST_PLAY       = 3'd2,
        ST_BALL_OUT   = 3'd3,
        ST_GAME_OVER  = 3'd4
    } game_state_e;

    localparam int DEF_BALL_OUT_FRAMES  = 60;
    localparam int DEF_GAME_OVER_FRAMES = 120;
    localparam int DEF_CREDIT_MAX       = 15;

    localparam int CREDIT_W = 4;
    localparam int BALLS_W  = 3;

    // Balls granted to each player at game start, chosen by the ball-count switch
    function automatic logic [BALLS_W-1:0] balls_per_game(input logic five_ball);
        return five_ball ? BALLS_W'(5) : BALLS_W'(3);
    endfunction

endpackage

// File: rtl/credit_counter.sv
// rtl/credit_counter.sv - credit accumulator with coin add, start debit and saturation
module credit_counter
    import breakout_pkg::*;
#(
    parameter int CREDIT_MAX = DEF_CREDIT_MAX
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                coin_i,
    input  logic                double_i,
    input  logic [1:0]          debit_i,
    output logic [CREDIT_W-1:0] credits_o
);

    localparam int W = CREDIT_W + 2;
    localparam logic [W-1:0] SAT = W'(CREDIT_MAX);

    logic [CREDIT_W-1:0] credits_q, credits_d;
    logic [W-1:0]        add_w, sum_w, debit_w, net_w;

    // Net of coin and debit is formed first, then clamped to the ceiling
    always_comb begin
        add_w   = '0;
        if (coin_i) begin
            add_w = double_i ? W'(2) : W'(1);
        end
        sum_w   = W'(credits_q) + add_w;
        debit_w = W'(debit_i);
        net_w   = (sum_w < debit_w) ? '0 : (sum_w - debit_w);
        credits_d = (net_w > SAT) ? CREDIT_W'(CREDIT_MAX) : net_w[CREDIT_W-1:0];
    end

    // Credit register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            credits_q <= '0;
        end else begin
            credits_q <= credits_d;
        end
    end

    assign credits_o = credits_q;

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - coin-op game mode sequencer: credits, serves, ball turns, game over
module game_sequencer
    import breakout_pkg::*;
#(
    parameter int BALL_OUT_FRAMES  = DEF_BALL_OUT_FRAMES,
    parameter int GAME_OVER_FRAMES = DEF_GAME_OVER_FRAMES,
    parameter int CREDIT_MAX       = DEF_CREDIT_MAX
) (
    input  logic                clk_drv_i,
    input  logic                reset_i,
    input  logic                frame_tick_i,
    input  logic                coin_i,
    input  logic                s3_i,
    input  logic                s4_i,
    input  logic                p1_start_n_i,
    input  logic                p2_start_n_i,
    input  logic                serve_n_i,
    input  logic                ball_lost_i,
    input  logic                wall_cleared_i,
    output logic                attract_o,
    output logic                serve_wait_o,
    output logic                ball_active_o,
    output logic                player2_o,
    output logic                set_bricks_o,
    output logic [BALLS_W-1:0]  balls_left_o,
    output logic [CREDIT_W-1:0] credits_o,
    output logic [2:0]          state_o
);

    localparam int FRAME_MAX = (BALL_OUT_FRAMES > GAME_OVER_FRAMES) ? BALL_OUT_FRAMES
                                                                    : GAME_OVER_FRAMES;
    localparam int CNT_W = $clog2(FRAME_MAX + 1);

    game_state_e         state_q, state_d;
    logic [BALLS_W-1:0]  balls1_q, balls1_d;
    logic [BALLS_W-1:0]  balls2_q, balls2_d;
    logic                player2_q, player2_d;
    logic                two_player_q, two_player_d;
    logic                wall_pending_q, wall_pending_d;
    logic                set_bricks_q, set_bricks_d;
    logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic                entry_q;

    logic [1:0]          debit;
    logic                start_game;
    logic                count_tick;
    logic [BALLS_W-1:0]  cur_balls, other_balls;
    logic [CREDIT_W-1:0] credits;

    credit_counter #(
        .CREDIT_MAX (CREDIT_MAX)
    ) u_credit_counter (
        .clk_i     (clk_drv_i),
        .reset_i   (reset_i),
        .coin_i    (coin_i),
        .double_i  (s3_i),
        .debit_i   (debit),
        .credits_o (credits)
    );

    // Next-state, turn bookkeeping and frame counting for the game flow
    always_comb begin
        state_d        = state_q;
        balls1_d       = balls1_q;
        balls2_d       = balls2_q;
        player2_d      = player2_q;
        two_player_d   = two_player_q;
        wall_pending_d = wall_pending_q;
        set_bricks_d   = 1'b0;
        frame_cnt_d    = frame_cnt_q;
        debit          = 2'd0;
        start_game     = 1'b0;
        // A tick landing in the first cycle of a state is not counted
        count_tick     = frame_tick_i && !entry_q;
        cur_balls      = player2_q ? balls2_q : balls1_q;
        other_balls    = player2_q ? balls1_q : balls2_q;

        case (state_q)
            ST_ATTRACT: begin
                if (!p2_start_n_i && credits >= CREDIT_W'(2)) begin
                    debit        = 2'd2;
                    two_player_d = 1'b1;
                    start_game   = 1'b1;
                end else if (!p1_start_n_i && credits >= CREDIT_W'(1)) begin
                    debit        = 2'd1;
                    two_player_d = 1'b0;
                    start_game   = 1'b1;
                end
                if (start_game) begin
                    balls1_d       = balls_per_game(s4_i);
                    balls2_d       = (debit == 2'd2) ? balls_per_game(s4_i) : '0;
                    player2_d      = 1'b0;
                    wall_pending_d = 1'b0;
                    set_bricks_d   = 1'b1;
                    state_d        = ST_SERVE_WAIT;
                end
            end
            ST_SERVE_WAIT: begin
                if (!serve_n_i) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (wall_cleared_i) begin
                    wall_pending_d = 1'b1;
                end
                if (ball_lost_i) begin
                    if (cur_balls != '0) begin
                        if (player2_q) balls2_d = balls2_q - BALLS_W'(1);
                        else           balls1_d = balls1_q - BALLS_W'(1);
                    end
                    state_d = ST_BALL_OUT;
                end
            end
            ST_BALL_OUT: begin
                if (count_tick) begin
                    if (frame_cnt_q == CNT_W'(BALL_OUT_FRAMES - 1)) begin
                        if (two_player_q && other_balls != '0) begin
                            player2_d = !player2_q;
                            state_d   = ST_SERVE_WAIT;
                        end else if (cur_balls != '0) begin
                            state_d   = ST_SERVE_WAIT;
                        end else begin
                            state_d   = ST_GAME_OVER;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_GAME_OVER: begin
                if (count_tick) begin
                    if (frame_cnt_q == CNT_W'(GAME_OVER_FRAMES - 1)) begin
                        state_d = ST_ATTRACT;
                    end else begin
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_ATTRACT;
            end
        endcase

        // A cleared wall is rebuilt as the next serve begins
        if (state_d == ST_SERVE_WAIT && state_q != ST_SERVE_WAIT && wall_pending_q) begin
            set_bricks_d   = 1'b1;
            wall_pending_d = 1'b0;
        end

        if (state_d != state_q) begin
            frame_cnt_d = '0;
        end
    end

    // State and bookkeeping registers
    always_ff @(posedge clk_drv_i) begin
        if (reset_i) begin
            state_q        <= ST_ATTRACT;
            balls1_q       <= '0;
            balls2_q       <= '0;
            player2_q      <= 1'b0;
            two_player_q   <= 1'b0;
            wall_pending_q <= 1'b0;
            set_bricks_q   <= 1'b0;
            frame_cnt_q    <= '0;
            entry_q        <= 1'b1;
        end else begin
            state_q        <= state_d;
            balls1_q       <= balls1_d;
            balls2_q       <= balls2_d;
            player2_q      <= player2_d;
            two_player_q   <= two_player_d;
            wall_pending_q <= wall_pending_d;
            set_bricks_q   <= set_bricks_d;
            frame_cnt_q    <= frame_cnt_d;
            entry_q        <= (state_d != state_q);
        end
    end

    assign attract_o     = (state_q == ST_ATTRACT);
    assign serve_wait_o  = (state_q == ST_SERVE_WAIT);
    assign ball_active_o = (state_q == ST_PLAY);
    assign player2_o     = player2_q;
    assign set_bricks_o  = set_bricks_q;
    assign balls_left_o  = player2_q ? balls2_q : balls1_q;
    assign credits_o     = credits;
    assign state_o       = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed and randomized checks of game_sequencer against a behavioural model
module tb_game_sequencer;
    import breakout_pkg::*;

    localparam int BO = 60;
    localparam int GO = 120;
    localparam int CM = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, frame_tick, coin, s3, s4, p1n, p2n, serven, lost, wall;
    logic attract_o, serve_wait_o, ball_active_o, player2_o, set_bricks_o;
    logic [2:0] balls_left_o;
    logic [3:0] credits_o;
    logic [2:0] state_o;

    game_sequencer #(
        .BALL_OUT_FRAMES  (BO),
        .GAME_OVER_FRAMES (GO),
        .CREDIT_MAX       (CM)
    ) dut (
        .clk_drv_i      (clk),
        .reset_i        (reset),
        .frame_tick_i   (frame_tick),
        .coin_i         (coin),
        .s3_i           (s3),
        .s4_i           (s4),
        .p1_start_n_i   (p1n),
        .p2_start_n_i   (p2n),
        .serve_n_i      (serven),
        .ball_lost_i    (lost),
        .wall_cleared_i (wall),
        .attract_o      (attract_o),
        .serve_wait_o   (serve_wait_o),
        .ball_active_o  (ball_active_o),
        .player2_o      (player2_o),
        .set_bricks_o   (set_bricks_o),
        .balls_left_o   (balls_left_o),
        .credits_o      (credits_o),
        .state_o        (state_o)
    );

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model of the game rules
    string m_phase = "ATTRACT";
    int    m_credits = 0;
    int    m_balls[2] = '{0, 0};
    bit    m_p2 = 0, m_two = 0, m_wall = 0, m_brick = 0, m_fresh = 1;
    int    m_frames = 0;

    function automatic logic [2:0] phase_code(string p);
        if (p == "ATTRACT")    return 3'(ST_ATTRACT);
        if (p == "SERVE_WAIT") return 3'(ST_SERVE_WAIT);
        if (p == "PLAY")       return 3'(ST_PLAY);
        if (p == "BALL_OUT")   return 3'(ST_BALL_OUT);
        return 3'(ST_GAME_OVER);
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_game(bit two);
        m_two      = two;
        m_balls[0] = s4 ? 5 : 3;
        m_balls[1] = two ? m_balls[0] : 0;
        m_p2       = 0;
        m_wall     = 0;
    endtask

    task automatic model_step();
        string nx = m_phase;
        int add, debit, cur;
        bit brick = 0;
        if (reset) begin
            m_phase = "ATTRACT"; m_credits = 0; m_balls[0] = 0; m_balls[1] = 0;
            m_p2 = 0; m_two = 0; m_wall = 0; m_brick = 0; m_fresh = 1; m_frames = 0;
            return;
        end
        add   = coin ? (s3 ? 2 : 1) : 0;
        debit = 0;
        cur   = m_p2 ? 1 : 0;
        if (m_phase == "ATTRACT") begin
            if (!p2n && m_credits >= 2) begin
                debit = 2; start_game(1); brick = 1; nx = "SERVE_WAIT";
            end else if (!p1n && m_credits >= 1) begin
                debit = 1; start_game(0); brick = 1; nx = "SERVE_WAIT";
            end
        end else if (m_phase == "SERVE_WAIT") begin
            if (!serven) nx = "PLAY";
        end else if (m_phase == "PLAY") begin
            if (wall) m_wall = 1;
            if (lost) begin
                if (m_balls[cur] > 0) m_balls[cur]--;
                nx = "BALL_OUT";
            end
        end else if (m_phase == "BALL_OUT") begin
            if (frame_tick && !m_fresh) begin
                m_frames++;
                if (m_frames == BO) begin
                    if (m_two && m_balls[1 - cur] > 0) begin
                        m_p2 = !m_p2; nx = "SERVE_WAIT";
                    end else if (m_balls[cur] > 0) begin
                        nx = "SERVE_WAIT";
                    end else begin
                        nx = "GAME_OVER";
                    end
                end
            end
        end else begin
            if (frame_tick && !m_fresh) begin
                m_frames++;
                if (m_frames == GO) nx = "ATTRACT";
            end
        end
        if (nx == "SERVE_WAIT" && m_phase != "SERVE_WAIT" && m_wall) begin
            brick = 1; m_wall = 0;
        end
        m_credits = m_credits + add - debit;
        if (m_credits > CM) m_credits = CM;
        m_fresh = (nx != m_phase);
        if (m_fresh) m_frames = 0;
        m_phase = nx;
        m_brick = brick;
    endtask

    task automatic compare_all();
        check("attract",     attract_o,     m_phase == "ATTRACT");
        check("serve_wait",  serve_wait_o,  m_phase == "SERVE_WAIT");
        check("ball_active", ball_active_o, m_phase == "PLAY");
        check("player2",     player2_o,     m_p2);
        check("set_bricks",  set_bricks_o,  m_brick);
        check("balls_left",  balls_left_o,  m_balls[m_p2 ? 1 : 0]);
        check("credits",     credits_o,     m_credits);
        check("state",       state_o,       phase_code(m_phase));
    endtask

    task automatic idle();
        reset = 0; frame_tick = 0; coin = 0; p1n = 1; p2n = 1;
        serven = 1; lost = 0; wall = 0;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        idle();
    endtask

    // Feed ticks every cycle until the state changes; returns cycles used
    task automatic run_ticks(output int n);
        logic [2:0] st0;
        st0 = state_o;
        n = 0;
        do begin
            frame_tick = 1;
            cycle();
            n++;
        end while (state_o == st0 && n < 400);
    endtask

    int n;

    initial begin
        s3 = 0; s4 = 0;
        idle();
        reset = 1; cycle();
        check("rst_attract", attract_o, 1);
        check("rst_credits", credits_o, 0);
        check("rst_balls",   balls_left_o, 0);

        // Coin accumulation and saturation
        repeat (3) begin coin = 1; cycle(); cycle(); end
        check("coin3", credits_o, 3);
        repeat (14) begin coin = 1; cycle(); end
        check("coin_sat", credits_o, 15);

        // One-player game through to game over
        reset = 1; cycle();
        coin = 1; cycle();
        p2n = 0; cycle();
        check("p2_ignored", attract_o, 1);
        check("p2_ignored_cr", credits_o, 1);
        p1n = 0; cycle();
        check("p1_credits", credits_o, 0);
        check("p1_bricks", set_bricks_o, 1);
        check("p1_serve_wait", serve_wait_o, 1);
        check("p1_balls", balls_left_o, 3);
        cycle();
        check("bricks_once", set_bricks_o, 0);
        for (int b = 0; b < 3; b++) begin
            serven = 0; cycle();
            check("serve_play", ball_active_o, 1);
            lost = 1; cycle();
            run_ticks(n);
            check("ball_out_cycles", n, BO + 1);
        end
        check("game_over", state_o, 3'(ST_GAME_OVER));
        run_ticks(n);
        check("game_over_cycles", n, GO + 1);
        check("back_attract", attract_o, 1);

        // Two-player alternation
        reset = 1; cycle();
        s4 = 1;
        coin = 1; cycle();
        coin = 1; cycle();
        p2n = 0; p1n = 0; cycle();
        check("p2_start_cr", credits_o, 0);
        check("p2_start_balls", balls_left_o, 5);
        serven = 0; cycle();
        lost = 1; cycle();
        run_ticks(n);
        check("swap_p2", player2_o, 1);
        check("swap_p2_balls", balls_left_o, 5);
        serven = 0; cycle();
        lost = 1; cycle();
        run_ticks(n);
        check("swap_p1", player2_o, 0);
        check("swap_p1_balls", balls_left_o, 4);

        // Ball lost and wall cleared together
        serven = 0; cycle();
        lost = 1; wall = 1; cycle();
        check("dual_balls", balls_left_o, 3);
        run_ticks(n);
        check("dual_bricks", set_bricks_o, 1);
        check("dual_serve_wait", serve_wait_o, 1);

        // Mid-game reset
        serven = 0; cycle();
        check("mid_play", ball_active_o, 1);
        reset = 1; cycle();
        check("mid_attract", attract_o, 1);
        check("mid_credits", credits_o, 0);
        check("mid_active", ball_active_o, 0);

        // Coin and start debit in the same cycle
        s3 = 1;
        coin = 1; cycle();
        coin = 1; p1n = 0; cycle();
        check("net_credits", credits_o, 3);
        s3 = 0;

        // Randomized play
        reset = 1; cycle();
        for (int i = 0; i < 9000; i++) begin
            reset      = ($urandom_range(0, 1999) == 0);
            coin       = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0) s3 = ~s3;
            s4         = $urandom_range(0, 1) == 1;
            p1n        = !($urandom_range(0, 9) == 0);
            p2n        = !($urandom_range(0, 9) == 0);
            serven     = !($urandom_range(0, 3) == 0);
            lost       = ($urandom_range(0, 14) == 0);
            wall       = ($urandom_range(0, 14) == 0);
            frame_tick = $urandom_range(0, 1) == 1;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter BALL_OUT_FRAMES, default 60, frames held in BALL_OUT before the next serve or swap.
REQ-002 Parameter GAME_OVER_FRAMES, default 120, frames held in GAME_OVER before returning to ATTRACT.
REQ-003 Parameter CREDIT_MAX, default 15, saturation value of the credit count.
REQ-004 CLK_DRV  in  1  sole clock; the block shall use one clock; all state updates on the rising edge.
REQ-005 RESET  in  1  reset; it shall be synchronous and active-high.
REQ-006 FRAME_TICK  in  1  one-cycle pulse per video frame.
REQ-007 COIN  in  1  one-cycle pulse per accepted coin.
REQ-008 S3  in  1  0: 1 credit/coin, 1: 2 credits/coin.
REQ-009 S4  in  1  0: 3 balls, 1: 5 balls.
REQ-010 P1_START_N, P2_START_N, SERVE_N  in  1 each  active-low buttons, already debounced.
REQ-011 BALL_LOST, WALL_CLEARED  in  1 each  one-cycle event pulses from the playfield logic.
REQ-012 ATTRACT, SERVE_WAIT, BALL_ACTIVE, PLAYER2  out  1 each  mode flags.
REQ-013 SET_BRICKS  out  1  one-cycle wall-reload pulse.
REQ-014 BALLS_LEFT  out  3  balls remaining for the current player.
REQ-015 CREDITS  out  4  credit count.
REQ-016 STATE  out  3  encoded state for debug.

Function
REQ-017 States: ATTRACT, SERVE_WAIT, PLAY, BALL_OUT, GAME_OVER; STATE shall carry the encoding defined in the package.
REQ-018 COIN shall add 1, or 2 if S3=1, to CREDITS in any state, saturating at CREDIT_MAX.
REQ-019 In ATTRACT, a P1 start with CREDITS>=1 shall subtract 1 and start a 1-player game; a P2 start with CREDITS>=2 shall subtract 2 and start a 2-player game; with insufficient credits the start shall be ignored.
REQ-020 If P1 and P2 start are pressed in the same cycle, P2 shall have priority when CREDITS>=2, otherwise P1.
REQ-021 If COIN and a start debit occur in the same cycle, CREDITS shall take the net value, computed before saturation.
REQ-022 Game start shall: load each active player's ball count with 3, or 5 if S4=1 (S4 latched); clear PLAYER2; pulse SET_BRICKS; enter SERVE_WAIT.
REQ-023 SERVE_WAIT to PLAY shall occur on SERVE_N=0; BALL_ACTIVE=1 only in PLAY.
REQ-024 In PLAY, BALL_LOST shall decrement the current player's count and enter BALL_OUT.
REQ-025 In PLAY, WALL_CLEARED shall set a wall-pending flag.
REQ-026 If BALL_LOST and WALL_CLEARED occur in the same cycle, both actions shall apply.
REQ-027 BALL_OUT shall count BALL_OUT_FRAMES FRAME_TICKs, then select the next player:
  - 2-player game and the other player's count is nonzero: toggle PLAYER2, then SERVE_WAIT;
  - else current player's count nonzero: same player, SERVE_WAIT;
  - else: GAME_OVER.
REQ-028 On every entry to SERVE_WAIT with wall-pending set, SET_BRICKS shall pulse in the entry cycle and the flag shall clear.
REQ-029 WALL_CLEARED outside PLAY shall be ignored.
REQ-030 GAME_OVER shall count GAME_OVER_FRAMES FRAME_TICKs, then enter ATTRACT; ATTRACT=1 only in ATTRACT.
REQ-031 BALL_LOST outside PLAY shall be ignored; ball counts shall never underflow below 0.
REQ-032 BALLS_LEFT shall show the count of the player selected by PLAYER2.
REQ-033 Frame counters shall clear on every state entry; a FRAME_TICK in the entry cycle shall not count.

Reset
REQ-034 RESET=1 shall force, on the next edge: ATTRACT state; CREDITS=0; both ball counts 0; PLAYER2=0; wall-pending=0; counters 0; SET_BRICKS=0; SERVE_WAIT=0; BALL_ACTIVE=0; ATTRACT=1.
REQ-035 RESET asserted mid-game shall abandon the game immediately; no credits shall be refunded.

Structure
REQ-036 The state enum, STATE encoding, and default frame constants shall be defined in shared package breakout_pkg.
REQ-037 Credit add/debit/saturation logic shall live in sub-module credit_counter; all other logic shall be inline.

Verification
REQ-038 Coin sequence: S3=0, 3 COIN pulses -> CREDITS=3; 14 more COIN pulses -> CREDITS=15 (saturated).
REQ-039 1-player game: CREDITS=1, P2 start -> ignored; P1 start -> CREDITS=0, SET_BRICKS 1 cycle, SERVE_WAIT, BALLS_LEFT=3.
REQ-040 2-player alternation: S4=1, P2 start, then serve and BALL_LOST -> after 60 FRAME_TICKs PLAYER2=1, BALLS_LEFT=5; second loss -> PLAYER2=0, BALLS_LEFT=4.
REQ-041 Simultaneous events: BALL_LOST and WALL_CLEARED in one cycle -> BALLS_LEFT decrements; SET_BRICKS pulses on SERVE_WAIT entry.
REQ-042 Game end: last ball lost in 1-player game -> GAME_OVER; after 120 FRAME_TICKs -> ATTRACT=1.
REQ-043 Mid-game reset: RESET in PLAY -> next cycle ATTRACT=1, CREDITS=0, BALL_ACTIVE=0.
